timer_counter: RTL and testbench
================================

TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL expose parameter PRESET_RST, default 32'h0000_0000, PRESET register reset value.
REQ-002 SHALL expose port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL expose port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL expose port addr  input  2  word offset from bridge (Pr address bits [3:2]).
REQ-005 SHALL expose port we  input  1  write strobe for the selected register.
REQ-006 SHALL expose port wd  input  32  write data.
REQ-007 SHALL expose port rd  output  32  read data of the addressed register, combinational.
REQ-008 SHALL expose port irq  output  1  interrupt request, routed to one HWInt bit of the CPU.

Function
REQ-009 SHALL map registers by addr: 0 = CTRL, 1 = PRESET, 2 = COUNT (read-only), 3 = reserved (reads 0, writes ignored).
REQ-010 SHALL define CTRL bits: [0] EN, [2:1] MODE, [3] IM; bits [31:4] read 0 and are not stored.
REQ-011 SHALL treat MODE 00 as one-shot and MODE 01 as auto-reload; MODE 10/11 SHALL behave as 00.
REQ-012 SHALL implement FSM states IDLE, LOAD, CNT, INT.
REQ-013 IDLE: if EN=1, next state LOAD; else remain.
REQ-014 LOAD: COUNT <= PRESET; next state CNT.
REQ-015 CNT: if EN=0, next state IDLE with COUNT held; else if COUNT=0, next state INT; else COUNT <= COUNT-1.
REQ-016 INT, one-shot: EN <= 0, IRQF <= 1, next state IDLE.
REQ-017 INT, auto-reload: IRQF <= 1 for exactly one cycle, next state LOAD.
REQ-018 SHALL drive irq = IRQF & IM; one-shot IRQF SHALL hold until any CTRL write.
REQ-019 Latency: EN set at edge t, with PRESET=N, gives LOAD at t+1, COUNT=N after t+1, IRQF=1 after edge t+N+3.
REQ-020 PRESET=0 SHALL reach INT two cycles after LOAD, with no underflow.
REQ-021 COUNT SHALL never wrap; decrement only occurs while COUNT>0.
REQ-022 A PRESET write during CNT SHALL not alter COUNT until the next LOAD.
REQ-023 A CTRL write in the same cycle as INT clearing EN SHALL win: the written EN value is kept, and IRQF is cleared.
REQ-024 Writes to COUNT and reserved offsets SHALL have no effect.
REQ-025 A CTRL write with EN=0 in any state SHALL return the FSM to IDLE on the next CNT evaluation; from LOAD it SHALL still complete the load.

Reset
REQ-026 Reset SHALL force state IDLE, CTRL=0, PRESET=PRESET_RST, COUNT=0, IRQF=0, and hence irq=0 immediately and asynchronously.
REQ-027 Reset asserted mid-count SHALL abort the countdown; no irq SHALL appear after deassertion until software re-enables the timer.

Structure
REQ-028 SHALL place register offsets, CTRL bit positions, MODE encodings and FSM state encoding in the shared package used by the CPU bridge.
REQ-029 SHALL be a single module with no sub-module; register file and FSM both live in it.

Verification
REQ-030 Reset mid-CNT with COUNT=5 -> COUNT=0, CTRL=0, irq=0 immediately, and no later irq.
REQ-031 PRESET=3, CTRL=4'b1001 (EN, one-shot, IM) -> irq rises 6 edges after the CTRL write, EN reads 0, and irq holds until CTRL is written 0.
REQ-032 PRESET=2, CTRL=4'b1011 (auto-reload, IM) -> irq is a one-cycle pulse every 5 cycles, and COUNT reads 2,1,0 repeating.
REQ-033 PRESET=0, one-shot, IM=0 -> IRQF set after 3 edges, irq stays 0; writing IM=1 clears IRQF, so irq stays 0.
REQ-034 During CNT write PRESET=9, then EN=0 at COUNT=4 -> COUNT holds 4; EN=1 reloads COUNT to 9.
REQ-035 CTRL write EN=1 in the same cycle as one-shot INT -> EN reads 1, IRQF=0, and the FSM restarts via IDLE, LOAD.

Source files
------------

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the timer/counter peripheral and the CPU bridge that decodes it.
// Holds the register word offsets, the CTRL bit positions, the MODE encodings and the FSM
// state encoding.
package timer_counter_pkg;

  localparam int unsigned DataWidth = 32;

  // Register word offsets (bridge address bits [3:2])
  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrPreset = 2'd1;
  localparam logic [1:0] AddrCount  = 2'd2;
  localparam logic [1:0] AddrRsvd   = 2'd3;

  // CTRL bit positions; bits [31:4] are not stored and read as zero
  localparam int unsigned CtrlEnBit   = 0;
  localparam int unsigned CtrlModeLsb = 1;
  localparam int unsigned CtrlModeMsb = 2;
  localparam int unsigned CtrlImBit   = 3;

  // MODE encodings; 2'b10 and 2'b11 fall back to one-shot behaviour
  localparam logic [1:0] ModeOneShot    = 2'b00;
  localparam logic [1:0] ModeAutoReload = 2'b01;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StCnt  = 2'd2,
    StInt  = 2'd3
  } state_e;

  function automatic logic is_auto_reload(input logic [1:0] mode);
    return mode == ModeAutoReload;
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Register bus between the CPU bridge and the timer/counter.
//   addr : word offset of the selected register
//   we   : write strobe for the selected register
//   wd   : write data
//   rd   : combinational read data of the selected register
//   irq  : interrupt request towards the CPU
interface timer_counter_if;
  import timer_counter_pkg::*;

  logic [1:0]           addr;
  logic                 we;
  logic [DataWidth-1:0] wd;
  logic [DataWidth-1:0] rd;
  logic                 irq;

  modport master (
    output addr,
    output we,
    output wd,
    input  rd,
    input  irq
  );

  modport slave (
    input  addr,
    input  we,
    input  wd,
    output rd,
    output irq
  );

endinterface

// File: rtl/timer_counter.sv
// Programmable down-counting timer with one-shot and auto-reload modes.
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   reset : asynchronous active-high reset
//   bus   : register bus (slave side): addr/we/wd in, rd/irq out
// Registers: CTRL (EN, MODE, IM), PRESET (reload value), COUNT (read-only), reserved.
// irq = IRQF & IM. One-shot IRQF holds until software writes CTRL; auto-reload IRQF is a
// single-cycle pulse per period.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
  input logic            clk,
  input logic            reset,
  timer_counter_if.slave bus
);

  state_e state_q, state_d;

  logic                 en_q;
  logic [1:0]           mode_q;
  logic                 im_q;
  logic [DataWidth-1:0] preset_q;
  logic [DataWidth-1:0] count_q;
  logic                 irqf_q;

  logic ctrl_we;
  logic preset_we;
  logic auto_reload;
  logic load_count;
  logic dec_count;
  logic set_irqf;
  logic clr_irqf_pulse;
  logic clr_en_oneshot;

  assign ctrl_we     = bus.we && (bus.addr == AddrCtrl);
  assign preset_we   = bus.we && (bus.addr == AddrPreset);
  assign auto_reload = is_auto_reload(mode_q);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (en_q) state_d = StLoad;
      StLoad: state_d = StCnt;
      StCnt: begin
        if (!en_q) begin
          state_d = StIdle;
        end else if (count_q == '0) begin
          state_d = StInt;
        end
      end
      StInt:   state_d = auto_reload ? StLoad : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs and datapath strobes
  always_comb begin
    // COUNT is captured on the edge that enters LOAD, so it already holds PRESET during LOAD
    load_count     = (state_d == StLoad) && (state_q != StLoad);
    dec_count      = (state_q == StCnt) && en_q && (count_q != '0);
    // IRQF rises on the edge that enters INT
    set_irqf       = (state_q == StCnt) && (state_d == StInt);
    clr_irqf_pulse = (state_q == StInt) && auto_reload;
    clr_en_oneshot = (state_q == StInt) && !auto_reload;

    bus.irq = irqf_q & im_q;
    bus.rd  = '0;
    unique case (bus.addr)
      AddrCtrl:   bus.rd = {{(DataWidth-4){1'b0}}, im_q, mode_q, en_q};
      AddrPreset: bus.rd = preset_q;
      AddrCount:  bus.rd = count_q;
      AddrRsvd:   bus.rd = '0;
      default:    bus.rd = '0;
    endcase
  end

  // Register file and counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q     <= 1'b0;
      mode_q   <= ModeOneShot;
      im_q     <= 1'b0;
      preset_q <= PRESET_RST;
      count_q  <= '0;
      irqf_q   <= 1'b0;
    end else begin
      // A CTRL write beats the one-shot EN clear from INT
      if (ctrl_we) begin
        en_q   <= bus.wd[CtrlEnBit];
        mode_q <= bus.wd[CtrlModeMsb:CtrlModeLsb];
        im_q   <= bus.wd[CtrlImBit];
      end else if (clr_en_oneshot) begin
        en_q <= 1'b0;
      end

      if (preset_we) begin
        preset_q <= bus.wd;
      end

      if (load_count) begin
        count_q <= preset_q;
      end else if (dec_count) begin
        count_q <= count_q - 1'b1;
      end

      // Any CTRL write acknowledges the interrupt, even in the cycle it would be raised
      if (ctrl_we) begin
        irqf_q <= 1'b0;
      end else if (set_irqf) begin
        irqf_q <= 1'b1;
      end else if (clr_irqf_pulse) begin
        irqf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: a stimulus process drives one bus operation per cycle, steps a
// behavioural model of the timer and queues the expected read data and irq; a monitor
// process compares the DUT against the queue one step after each rising edge.
module tb_timer_counter;

  localparam logic [31:0] PresetRst = 32'h0000_0007;

  logic clk;
  logic reset;

  timer_counter_if bus ();

  timer_counter #(
    .PRESET_RST(PresetRst)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Timer phases: 0 waiting for EN, 1 arming (COUNT just loaded), 2 counting down,
  // 3 expiry cycle.
  int          m_phase;
  bit          m_en;
  bit [1:0]    m_mode;
  bit          m_im;
  bit [31:0]   m_preset;
  bit [31:0]   m_count;
  bit          m_irqf;

  task automatic model_reset();
    m_phase  = 0;
    m_en     = 1'b0;
    m_mode   = 2'b00;
    m_im     = 1'b0;
    m_preset = PresetRst;
    m_count  = 32'd0;
    m_irqf   = 1'b0;
  endtask

  // One rising edge: timer behaviour from the pre-edge values, then software writes on top.
  task automatic model_step(input bit we, input bit [1:0] addr, input bit [31:0] wd);
    int        phase  = m_phase;
    bit        en     = m_en;
    bit        reload = (m_mode == 2'b01);
    bit [31:0] cnt    = m_count;
    bit [31:0] pre    = m_preset;
    int        nphase = phase;
    case (phase)
      0: if (en) begin nphase = 1; m_count = pre; end
      1: nphase = 2;
      2: begin
        if (!en) nphase = 0;
        else if (cnt == 32'd0) begin nphase = 3; m_irqf = 1'b1; end
        else m_count = cnt - 32'd1;
      end
      default: begin
        if (reload) begin nphase = 1; m_count = pre; m_irqf = 1'b0; end
        else begin nphase = 0; m_en = 1'b0; end
      end
    endcase
    if (we && addr == 2'd0) begin
      m_en   = wd[0];
      m_mode = wd[2:1];
      m_im   = wd[3];
      m_irqf = 1'b0;
    end
    if (we && addr == 2'd1) m_preset = wd;
    m_phase = nphase;
  endtask

  function automatic logic [31:0] model_rd(input bit [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0]  addr;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("sb_rd[%0d]", e.addr), bus.rd, e.rd);
        check("sb_irq", 32'(bus.irq), 32'(e.irq));
      end
    end
  end

  // One bus operation across one rising edge; returns 2 units after that edge.
  task automatic cyc(input bit we, input bit [1:0] addr, input bit [31:0] wd);
    exp_t e;
    @(negedge clk);
    bus.we   = we;
    bus.addr = addr;
    bus.wd   = wd;
    model_step(we, addr, wd);
    e.addr = addr;
    e.rd   = model_rd(addr);
    e.irq  = m_irqf & m_im;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic quiesce();
    cyc(1'b1, 2'd0, 32'd0);
    repeat (4) cyc(1'b0, 2'd2, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_k;
    int pulses;
    int bad;
    int highs;
    bit found;

    reset    = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 2'd0;
    bus.wd   = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_ctrl", bus.rd, 32'd0);
    check("reset_irq", 32'(bus.irq), 32'd0);
    reset = 1'b0;

    // Reset values of every offset
    for (int a = 0; a < 4; a++) cyc(1'b0, 2'(a), 32'd0);
    check("reset_preset_val", model_rd(2'd1), PresetRst);

    // Writes to COUNT and the reserved offset are ignored
    cyc(1'b1, 2'd2, 32'hDEAD_BEEF);
    cyc(1'b1, 2'd3, 32'h1234_5678);
    cyc(1'b0, 2'd2, 32'd0);
    check("count_wr_ignored", bus.rd, 32'd0);

    // One-shot: irq rises 6 edges after the CTRL write, EN clears, irq holds
    cyc(1'b1, 2'd1, 32'd3);
    cyc(1'b1, 2'd0, 32'h9);
    first_k = -1;
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b0, 2'd0, 32'd0);
      if (bus.irq === 1'b1 && first_k < 0) first_k = k;
    end
    check("oneshot_irq_edge", 32'(first_k), 32'd6);
    check("oneshot_en_clear", bus.rd, 32'h8);
    check("oneshot_irq_hold", 32'(bus.irq), 32'd1);
    cyc(1'b1, 2'd0, 32'd0);
    check("oneshot_irq_ack", 32'(bus.irq), 32'd0);
    quiesce();

    // Auto-reload with PRESET=2: one-cycle pulse every 5 cycles
    cyc(1'b1, 2'd1, 32'd2);
    cyc(1'b1, 2'd0, 32'hB);
    pulses = 0;
    bad = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 2'd2, 32'd0);
      if (bus.irq === 1'b1) begin
        pulses++;
        if (k % 5 != 0) bad++;
      end
      if (k % 5 == 3) check("reload_count", bus.rd, 32'd1);
    end
    check("reload_pulses", 32'(pulses), 32'd4);
    check("reload_pulse_pos", 32'(bad), 32'd0);
    quiesce();

    // PRESET=0 one-shot with IM=0: irq stays low, later IM=1 write clears IRQF
    cyc(1'b1, 2'd1, 32'd0);
    cyc(1'b1, 2'd0, 32'h1);
    highs = 0;
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 2'd0, 32'd0);
      if (bus.irq === 1'b1) highs++;
    end
    check("masked_irq_low", 32'(highs), 32'd0);
    cyc(1'b1, 2'd0, 32'h8);
    cyc(1'b0, 2'd0, 32'd0);
    check("im_write_clears", 32'(bus.irq), 32'd0);
    quiesce();

    // PRESET write mid-count, stop at COUNT=4, restart reloads the new PRESET
    cyc(1'b1, 2'd1, 32'd20);
    cyc(1'b1, 2'd0, 32'h1);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cyc(1'b0, 2'd2, 32'd0);
      if (bus.rd == 32'd10) found = 1'b1;
    end
    check("midcount_reach10", 32'(found), 32'd1);
    cyc(1'b1, 2'd1, 32'd9);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cyc(1'b0, 2'd2, 32'd0);
      if (bus.rd == 32'd5) found = 1'b1;
    end
    check("midcount_reach5", 32'(found), 32'd1);
    cyc(1'b1, 2'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 2'd2, 32'd0);
      check("stop_count_hold", bus.rd, 32'd4);
    end
    cyc(1'b1, 2'd0, 32'h1);
    cyc(1'b0, 2'd2, 32'd0);
    check("restart_reload", bus.rd, 32'd9);
    quiesce();

    // CTRL write in the one-shot INT cycle wins
    cyc(1'b1, 2'd1, 32'd3);
    cyc(1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 6; k++) cyc(1'b0, 2'd0, 32'd0);
    check("int_irq_set", 32'(bus.irq), 32'd1);
    cyc(1'b1, 2'd0, 32'h9);
    check("int_wr_irq_clr", 32'(bus.irq), 32'd0);
    check("int_wr_en_kept", bus.rd, 32'h9);
    cyc(1'b0, 2'd2, 32'd0);
    check("int_wr_reload", bus.rd, 32'd3);
    quiesce();

    // Asynchronous reset mid-count
    cyc(1'b1, 2'd1, 32'd10);
    cyc(1'b1, 2'd0, 32'h9);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cyc(1'b0, 2'd2, 32'd0);
      if (bus.rd == 32'd5) found = 1'b1;
    end
    check("rst_reach5", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_count_now", bus.rd, 32'd0);
    check("rst_irq_now", 32'(bus.irq), 32'd0);
    bus.addr = 2'd0;
    #1;
    check("rst_ctrl_now", bus.rd, 32'd0);
    model_reset();
    @(negedge clk);
    bus.we = 1'b0;
    reset  = 1'b0;
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 2'(k % 3), 32'd0);
      if (bus.irq === 1'b1) highs++;
    end
    check("rst_no_late_irq", 32'(highs), 32'd0);

    // Randomised traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int unsigned r;
      bit [31:0]   d;
      r = $urandom_range(0, 99);
      if (r < 70) begin
        cyc(1'b0, 2'($urandom_range(0, 3)), $urandom);
      end else if (r < 82) begin
        d = $urandom;
        d[0] = ($urandom_range(0, 3) != 0);
        cyc(1'b1, 2'd0, d);
      end else if (r < 92) begin
        cyc(1'b1, 2'd1, 32'($urandom_range(0, 6)));
      end else begin
        cyc(1'b1, 2'($urandom_range(2, 3)), $urandom);
      end
    end

    @(negedge clk);
    bus.we = 1'b0;
    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
